// File: rtl/kuuga_bram_port_arbiter_if.sv
// Core-side request/response signals and the single BRAM port for kuuga_bram_port_arbiter.
// The arbiter uses the slave modport; the core and the BRAM model use the master modport.
interface kuuga_bram_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic              data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-3:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_addr, data_we, data_be, data_wdata, bram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_addr, data_we, data_be, data_wdata, bram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/kuuga_bram_port_arbiter.sv
// Shares one single-port 32-bit BRAM between instruction-fetch and data requesters.
// Define KUUGA_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise data always beats instruction.
module kuuga_bram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  kuuga_bram_port_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("kuuga_bram_port_arbiter: READ_LATENCY must be 1..4");
  end

  logic                    conflict;
  logic                    data_pri;
  logic                    inst_gnt;
  logic                    data_gnt;
  logic                    bram_en;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] own_q, own_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    unused_addr_lsbs;

  assign conflict         = bus.inst_req & bus.data_req;
  assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

`ifdef KUUGA_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a conflict the side that was not served last gets the port.
  assign data_pri = (last_owner_q == OWN_INST);

  always_comb begin
    last_owner_d = last_owner_q;
    if (data_gnt)      last_owner_d = OWN_DATA;
    else if (inst_gnt) last_owner_d = OWN_INST;
  end

  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= OWN_INST;
    else       last_owner_q <= last_owner_d;
  end
`else
  assign data_pri = 1'b1;
`endif

  always_comb begin
    data_gnt = ~reset & bus.data_req & (~bus.inst_req | data_pri);
    inst_gnt = ~reset & bus.inst_req & ~(bus.data_req & data_pri);
    bram_en  = inst_gnt | data_gnt;
  end

  always_comb begin
    vld_d[0] = bram_en;
    own_d[0] = data_gnt ? OWN_DATA : OWN_INST;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.inst_gnt   = inst_gnt;
  assign bus.data_gnt   = data_gnt;
  assign bus.bram_en    = bram_en;
  assign bus.bram_addr  = data_gnt ? bus.data_addr[ADDR_W-1:2] : bus.inst_addr[ADDR_W-1:2];
  assign bus.bram_we    = (data_gnt & bus.data_we) ? bus.data_be : 4'b0000;
  assign bus.bram_wdata = bus.data_wdata;

  // Gated by reset so a response due in the reset cycle itself is also dropped.
  assign bus.inst_rvalid = ~reset & vld_q[READ_LATENCY-1] & (own_q[READ_LATENCY-1] == OWN_INST);
  assign bus.data_rvalid = ~reset & vld_q[READ_LATENCY-1] & (own_q[READ_LATENCY-1] == OWN_DATA);
  assign bus.inst_rdata  = bus.bram_rdata;
  assign bus.data_rdata  = bus.bram_rdata;

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_kuuga_bram_port_arbiter.sv
// Bench for kuuga_bram_port_arbiter: two instances (read latency 1 and 2) driven by the same
// requests, each with its own BRAM model, checked against a grant-history reference model.
module tb_kuuga_bram_port_arbiter;
  localparam int MEM_W = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ireq, dreq, dwe;
  logic [15:0] iaddr, daddr;
  logic [3:0]  dbe;
  logic [31:0] dwd;
  logic [31:0] cnt0, cnt1;

  kuuga_bram_port_arbiter_if #(.ADDR_W(16)) bus0 ();
  kuuga_bram_port_arbiter_if #(.ADDR_W(16)) bus1 ();

  kuuga_bram_port_arbiter #(.ADDR_W(16), .READ_LATENCY(1), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .conflict_cnt(cnt0));
  kuuga_bram_port_arbiter #(.ADDR_W(16), .READ_LATENCY(2), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .conflict_cnt(cnt1));

  assign bus0.inst_req = ireq;  assign bus1.inst_req = ireq;
  assign bus0.inst_addr = iaddr; assign bus1.inst_addr = iaddr;
  assign bus0.data_req = dreq;  assign bus1.data_req = dreq;
  assign bus0.data_addr = daddr; assign bus1.data_addr = daddr;
  assign bus0.data_we = dwe;    assign bus1.data_we = dwe;
  assign bus0.data_be = dbe;    assign bus1.data_be = dbe;
  assign bus0.data_wdata = dwd; assign bus1.data_wdata = dwd;

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return (v * 32'h0101_0101) ^ 32'hA55A_3CC3;
  endfunction

  // Behavioural BRAMs, read-first, latency 1 and 2.
  logic [31:0] mem0 [MEM_W];
  logic [31:0] mem1 [MEM_W];
  logic [31:0] rp0, rp1a, rp1b;
  bit          mem_init = 1'b0;
  assign bus0.bram_rdata = rp0;
  assign bus1.bram_rdata = rp1b;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_W; i++) begin
        mem0[i] <= pat(i);
        mem1[i] <= pat(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (bus0.bram_en) begin
        rp0 <= mem0[bus0.bram_addr];
        for (int b = 0; b < 4; b++)
          if (bus0.bram_we[b]) mem0[bus0.bram_addr][8*b +: 8] <= bus0.bram_wdata[8*b +: 8];
      end
      if (bus1.bram_en) begin
        rp1a <= mem1[bus1.bram_addr];
        for (int b = 0; b < 4; b++)
          if (bus1.bram_we[b]) mem1[bus1.bram_addr][8*b +: 8] <= bus1.bram_wdata[8*b +: 8];
      end
      rp1b <= rp1a;
    end
  end

  // Reference model: a list of grants since reset; instance k answers grant g at cycle g+k+1.
  typedef struct {
    int          gcyc;
    bit          own;   // 1 = data
    bit          rd;
    logic [31:0] dat;
  } grant_t;

  grant_t      hist[$];
  logic [31:0] ref_mem [MEM_W];
  logic [31:0] cnt_m;
  bit          last_m;
  int          cyc;
  int          n_chk, n_fail;

  logic [1:0]  e_gnt;
  logic [50:0] e_bus;
  logic [31:0] e_cnt;
  logic [1:0]  e_rv [2];
  logic [31:0] e_rd [2];
  bit          e_rdchk [2];

  logic [1:0]  o_gnt [2];
  logic [1:0]  o_rv [2];
  logic [50:0] o_bus [2];
  logic [31:0] o_cnt [2];
  logic [31:0] o_ird [2];
  logic [31:0] o_drd [2];

  task automatic model_cycle();
    bit gi, gd, en;
    logic [13:0] wa;
    logic [3:0]  we;
    grant_t r;
    for (int k = 0; k < 2; k++) begin
      e_rv[k] = 2'b00; e_rdchk[k] = 1'b0; e_rd[k] = 32'h0;
      if (!reset)
        foreach (hist[i])
          if (hist[i].gcyc == cyc - k - 1) begin
            e_rv[k][hist[i].own] = 1'b1;
            e_rdchk[k] = hist[i].rd;
            e_rd[k] = hist[i].dat;
          end
    end
    gi = 1'b0; gd = 1'b0;
    if (!reset) begin
      if (ireq && dreq) begin
`ifdef KUUGA_ARB_ROUND_ROBIN_EN
        gd = (last_m == 1'b0);
`else
        gd = 1'b1;
`endif
        gi = !gd;
      end else begin
        gi = ireq; gd = dreq;
      end
    end
    en = gi | gd;
    wa = gd ? daddr[15:2] : iaddr[15:2];
    we = (gd && dwe) ? dbe : 4'b0000;
    e_gnt = {gd, gi};
    e_bus = {en, we, en ? wa : 14'h0, dwd};
    e_cnt = cnt_m;
    if (en) begin
      r.gcyc = cyc; r.own = gd; r.rd = gi || !dwe; r.dat = ref_mem[wa];
      hist.push_back(r);
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
      last_m = gd;
    end
    while (hist.size() > 0 && hist[0].gcyc < cyc - 2) void'(hist.pop_front());
    if (reset) begin
      hist.delete(); cnt_m = 32'h0; last_m = 1'b0;
    end else if (ireq && dreq && cnt_m != 32'hFFFF_FFFF) begin
      cnt_m = cnt_m + 32'h1;
    end
    cyc++;
  endtask

  // Sample both instances mid-cycle, advance the model, then move past the next rising edge.
  task automatic tick();
    @(negedge clk);
    o_gnt[0] = {bus0.data_gnt, bus0.inst_gnt};
    o_gnt[1] = {bus1.data_gnt, bus1.inst_gnt};
    o_rv[0]  = {bus0.data_rvalid, bus0.inst_rvalid};
    o_rv[1]  = {bus1.data_rvalid, bus1.inst_rvalid};
    o_bus[0] = {bus0.bram_en, bus0.bram_we, bus0.bram_en ? bus0.bram_addr : 14'h0, bus0.bram_wdata};
    o_bus[1] = {bus1.bram_en, bus1.bram_we, bus1.bram_en ? bus1.bram_addr : 14'h0, bus1.bram_wdata};
    o_cnt[0] = cnt0; o_cnt[1] = cnt1;
    o_ird[0] = bus0.inst_rdata; o_ird[1] = bus1.inst_rdata;
    o_drd[0] = bus0.data_rdata; o_drd[1] = bus1.data_rdata;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ir, input logic [15:0] ia, input bit dr, input logic [15:0] da,
                       input bit w, input logic [3:0] be, input logic [31:0] wd);
    ireq = ir; iaddr = ia; dreq = dr; daddr = da; dwe = w; dbe = be; dwd = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 16'h0020, 1'b1, 16'h0040, 1'b0, 4'hF, 32'h1234_5678);
    tick();
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_gnt[k] !== 2'b00) begin n_fail++; $display("FAIL reset_gnt dut%0d: got %b want 00", k, o_gnt[k]); end
        n_chk++; if (o_rv[k] !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid dut%0d: got %b want 00", k, o_rv[k]); end
        n_chk++; if (o_bus[k][50:46] !== 5'b0) begin n_fail++; $display("FAIL reset_en_we dut%0d: got %h want 0", k, o_bus[k][50:46]); end
        n_chk++; if (o_cnt[k] !== 32'h0) begin n_fail++; $display("FAIL reset_cnt dut%0d: got %0d want 0", k, o_cnt[k]); end
      end
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    tick();
  endtask

  task automatic test_directed();
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drive(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
        2: drive(1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        4: drive(1'b0, 16'h0000, 1'b1, 16'h0102, 1'b0, 4'hF, 32'h0);
        default: drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_gnt[k] !== e_gnt) begin n_fail++; $display("FAIL directed_gnt dut%0d step%0d: got %b want %b", k, s, o_gnt[k], e_gnt); end
        n_chk++; if (o_bus[k] !== e_bus) begin n_fail++; $display("FAIL directed_bram dut%0d step%0d: got %h want %h", k, s, o_bus[k], e_bus); end
        n_chk++; if (o_rv[k] !== e_rv[k]) begin n_fail++; $display("FAIL directed_rvalid dut%0d step%0d: got %b want %b", k, s, o_rv[k], e_rv[k]); end
        if (e_rdchk[k]) begin
          n_chk++;
          if ((e_rv[k][1] ? o_drd[k] : o_ird[k]) !== e_rd[k]) begin
            n_fail++; $display("FAIL directed_rdata dut%0d step%0d: got %h want %h", k, s, e_rv[k][1] ? o_drd[k] : o_ird[k], e_rd[k]);
          end
        end
      end
    end
  endtask

  task automatic test_conflict();
    for (int s = 0; s < 7; s++) begin
      if (s < 4) drive(1'b1, 16'h0030, 1'b1, 16'h0050, 1'b0, 4'hF, 32'h0);
      else       drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_gnt[k] !== e_gnt) begin n_fail++; $display("FAIL conflict_gnt dut%0d step%0d: got %b want %b", k, s, o_gnt[k], e_gnt); end
        n_chk++; if (o_rv[k] !== e_rv[k]) begin n_fail++; $display("FAIL conflict_rvalid dut%0d step%0d: got %b want %b", k, s, o_rv[k], e_rv[k]); end
        n_chk++; if (o_cnt[k] !== e_cnt) begin n_fail++; $display("FAIL conflict_cnt dut%0d step%0d: got %0d want %0d", k, s, o_cnt[k], e_cnt); end
        if (e_rdchk[k]) begin
          n_chk++;
          if ((e_rv[k][1] ? o_drd[k] : o_ird[k]) !== e_rd[k]) begin
            n_fail++; $display("FAIL conflict_rdata dut%0d step%0d: got %h want %h", k, s, e_rv[k][1] ? o_drd[k] : o_ird[k], e_rd[k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive(1'b1, 16'h0204, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
        1: drive(1'b0, 16'h0000, 1'b1, 16'h0308, 1'b0, 4'hF, 32'h0);
        2: drive(1'b1, 16'h040C, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
        default: drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_rv[k] !== e_rv[k]) begin n_fail++; $display("FAIL b2b_rvalid dut%0d step%0d: got %b want %b", k, s, o_rv[k], e_rv[k]); end
        if (e_rdchk[k]) begin
          n_chk++;
          if ((e_rv[k][1] ? o_drd[k] : o_ird[k]) !== e_rd[k]) begin
            n_fail++; $display("FAIL b2b_rdata dut%0d step%0d: got %h want %h", k, s, e_rv[k][1] ? o_drd[k] : o_ird[k], e_rd[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int s = 0; s < 7; s++) begin
      reset = (s == 1);
      case (s)
        0: drive(1'b1, 16'h0060, 1'b1, 16'h0070, 1'b0, 4'hF, 32'h0);
        1: drive(1'b1, 16'h0060, 1'b1, 16'h0070, 1'b0, 4'hF, 32'h0);
        3: drive(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
        default: drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0);
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_gnt[k] !== e_gnt) begin n_fail++; $display("FAIL midrst_gnt dut%0d step%0d: got %b want %b", k, s, o_gnt[k], e_gnt); end
        n_chk++; if (o_rv[k] !== e_rv[k]) begin n_fail++; $display("FAIL midrst_rvalid dut%0d step%0d: got %b want %b", k, s, o_rv[k], e_rv[k]); end
        n_chk++; if (o_cnt[k] !== e_cnt) begin n_fail++; $display("FAIL midrst_cnt dut%0d step%0d: got %0d want %0d", k, s, o_cnt[k], e_cnt); end
        n_chk++; if (o_bus[k] !== e_bus) begin n_fail++; $display("FAIL midrst_bram dut%0d step%0d: got %h want %h", k, s, o_bus[k], e_bus); end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit ip, dp;
    ip = 1'b0; dp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1; iaddr = 16'($urandom_range(0, 16'h03FF));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; daddr = 16'($urandom_range(0, 16'h03FF));
        dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
      end
      ireq = ip; dreq = dp;
      reset = ($urandom_range(0, 39) == 0);
      tick();
      if (e_gnt[0]) ip = 1'b0;
      if (e_gnt[1]) dp = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_gnt[k] !== e_gnt) begin n_fail++; $display("FAIL rand_gnt dut%0d cyc%0d: got %b want %b", k, cyc, o_gnt[k], e_gnt); end
        n_chk++; if (o_bus[k] !== e_bus) begin n_fail++; $display("FAIL rand_bram dut%0d cyc%0d: got %h want %h", k, cyc, o_bus[k], e_bus); end
        n_chk++; if (o_rv[k] !== e_rv[k]) begin n_fail++; $display("FAIL rand_rvalid dut%0d cyc%0d: got %b want %b", k, cyc, o_rv[k], e_rv[k]); end
        n_chk++; if (o_cnt[k] !== e_cnt) begin n_fail++; $display("FAIL rand_cnt dut%0d cyc%0d: got %0d want %0d", k, cyc, o_cnt[k], e_cnt); end
        if (e_rdchk[k]) begin
          n_chk++;
          if ((e_rv[k][1] ? o_drd[k] : o_ird[k]) !== e_rd[k]) begin
            n_fail++; $display("FAIL rand_rdata dut%0d cyc%0d: got %h want %h", k, cyc, e_rv[k][1] ? o_drd[k] : o_ird[k], e_rd[k]);
          end
        end
      end
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; cnt_m = 32'h0; last_m = 1'b0;
    for (int i = 0; i < MEM_W; i++) ref_mem[i] = pat(i);
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    test_reset();
    test_directed();
    test_conflict();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
